// File: rtl/clock_ctrl.sv
// clock_ctrl: timekeeping and mode controller for the multifunctional clock.
//
// Raw front-panel keys are synchronised, debounced on the 100 Hz sample
// strobe and reduced to single-cycle press pulses. The press pulses drive a
// RUN -> SET_HOUR -> SET_MIN -> RUN mode sequence. An HH:MM:SS counter
// advances on the 1 Hz tick while in RUN. A blink generator flags the field
// being edited in the set modes.
//
// Parameters:
//   DEBOUNCE_SAMPLES  consecutive equal 100 Hz samples needed to flip a key
//   BLINK_TICKS       100 Hz ticks per blink half-period
//
// Ports:
//   clk_50mhz   in   system clock; the only clock in the block
//   rst_n       in   synchronous, active-low reset
//   tick_1hz    in   one-cycle pulse per second
//   tick_100hz  in   one-cycle pulse every 10 ms; key sample strobe
//   key_mode    in   raw mode key, active-high, asynchronous, bouncing
//   key_inc     in   raw increment key, active-high, asynchronous, bouncing
//   hour        out  0..23
//   minute      out  0..59
//   second      out  0..59
//   mode        out  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   blink       out  blank the field selected by mode when high
//   on_hour     out  one-cycle chime pulse at the top of each hour
module clock_ctrl #(
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int BLINK_TICKS      = 50
) (
  input  logic       clk_50mhz,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tick_100hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink,
  output logic       on_hour
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  // Key index 0 is the mode key, index 1 the increment key.
  localparam int KEYS = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  logic [KEYS-1:0] sync_p0;
  logic [KEYS-1:0] sync_p1;
  logic [CW-1:0]   db_cnt_p2 [KEYS];
  logic [KEYS-1:0] stable_p2;
  logic [KEYS-1:0] press_p2;

  logic            p_mode;
  logic            p_inc;

  mode_t           state_q;
  logic [BW-1:0]   blink_cnt;

  // Hour counter step with wrap 23 -> 0.
  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  // Minute/second counter step with wrap 59 -> 0.
  function automatic logic [5:0] sexag_inc(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // ---- stage p0/p1: two-flop synchronizer on the raw keys ----
  // ---- stage p2: debounce and press-pulse extraction ----
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      stable_p2 <= '0;
      press_p2  <= '0;
      for (int k = 0; k < KEYS; k++) begin
        db_cnt_p2[k] <= '0;
      end
    end else begin
      sync_p0  <= {key_inc, key_mode};
      sync_p1  <= sync_p0;
      press_p2 <= '0;
      if (tick_100hz) begin
        for (int k = 0; k < KEYS; k++) begin
          if (sync_p1[k] != stable_p2[k]) begin
            // Reaching the sample count flips the state; the counter
            // therefore never exceeds DEBOUNCE_SAMPLES.
            if (db_cnt_p2[k] == CW'(DEBOUNCE_SAMPLES - 1)) begin
              stable_p2[k] <= ~stable_p2[k];
              db_cnt_p2[k] <= '0;
              press_p2[k]  <= ~stable_p2[k];
            end else begin
              db_cnt_p2[k] <= db_cnt_p2[k] + CW'(1);
            end
          end else begin
            db_cnt_p2[k] <= '0;
          end
        end
      end
    end
  end

  assign p_mode = press_p2[0];
  assign p_inc  = press_p2[1];

  // ---- stage p3: mode FSM, time counter, blink and chime ----
  always_ff @(posedge clk_50mhz) begin
    if (!rst_n) begin
      state_q   <= RUN;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      on_hour   <= 1'b0;
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      on_hour <= 1'b0;

      unique case (state_q)
        RUN: begin
          // A tick on the same edge as a mode press is still applied.
          if (tick_1hz) begin
            second <= sexag_inc(second);
            if (second == 6'd59) begin
              minute <= sexag_inc(minute);
              if (minute == 6'd59) begin
                hour    <= hour_inc(hour);
                on_hour <= 1'b1;
              end
            end
          end
          if (p_mode) begin
            state_q <= SET_HOUR;
          end
        end
        SET_HOUR: begin
          // Mode press wins over a simultaneous increment.
          if (p_mode) begin
            state_q <= SET_MIN;
          end else if (p_inc) begin
            hour <= hour_inc(hour);
          end
        end
        SET_MIN: begin
          // Leaving the set modes restarts the second count from zero.
          if (p_mode) begin
            state_q <= RUN;
            second  <= '0;
          end else if (p_inc) begin
            minute <= sexag_inc(minute);
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase

      // Blink restarts in phase on every mode change and is held off in RUN.
      if (p_mode || state_q == RUN) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (tick_100hz) begin
        if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign mode = state_q;

endmodule
